// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues single reads to a multi-cycle
// instruction memory, buffers one returned instruction for decode, follows
// branch redirects from execute and freezes after delivering an HLT.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HLT_OPC  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] instr_pc_plus2,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // Instruction addresses are halfword aligned; bit 0 is never honoured.
  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic [15:0] instr_pc_plus2_q, instr_pc_plus2_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q, halted_d;

  logic [15:0] redirect_target_s;
  logic [15:0] pc_inc_s;
  logic        is_hlt_s;

  assign redirect_target_s = redirect_pc & 16'hFFFE;
  assign pc_inc_s          = pc_q + 16'd2;          // wraps FFFE -> 0000
  assign is_hlt_s          = (instr_q[15:12] == HLT_OPC);

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_FETCH;
      pc_q             <= RESET_PC_ALIGNED;
      instr_q          <= 16'h0000;
      instr_pc_q       <= 16'h0000;
      instr_pc_plus2_q <= 16'h0000;
      instr_valid_q    <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      instr_q          <= instr_d;
      instr_pc_q       <= instr_pc_d;
      instr_pc_plus2_q <= instr_pc_plus2_d;
      instr_valid_q    <= instr_valid_d;
      halted_q         <= halted_d;
    end
  end

  // Next-state and datapath update: one request in flight, redirect wins.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    instr_d          = instr_q;
    instr_pc_d       = instr_pc_q;
    instr_pc_plus2_d = instr_pc_plus2_q;

    case (state_q)
      ST_FETCH: begin
        // Request is already on the bus this cycle; a redirect must still
        // drain its response before the new target can be fetched.
        if (redirect_en) begin
          pc_d    = redirect_target_s;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_en) begin
          pc_d = redirect_target_s;
          if (imem_valid) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (imem_valid) begin
          instr_d          = imem_rdata;
          instr_pc_d       = pc_q;
          instr_pc_plus2_d = pc_inc_s;
          pc_d             = pc_inc_s;
          state_d          = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (redirect_en) begin
          pc_d = redirect_target_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_valid) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        // Redirect squashes the buffered instruction even if decode takes it.
        if (redirect_en) begin
          pc_d    = redirect_target_s;
          state_d = ST_FETCH;
        end else if (decode_ready) begin
          if (is_hlt_s) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_FETCH;
        pc_d    = RESET_PC_ALIGNED;
      end
    endcase

    // Status flags are registered copies of the state being entered.
    instr_valid_d = (state_d == ST_HOLD);
    halted_d      = (state_d == ST_HALTED);
  end

  // Memory request strobe decoded from the current state.
  always_comb begin
    imem_req = 1'b0;
    if (state_q == ST_FETCH) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
  end

  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus2 = instr_pc_plus2_q;
  assign instr_valid    = instr_valid_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table drives the main flow
// (sequential fetch, backpressure, redirects, wrap, halt) and hand-written
// sequences cover the halted freeze and asynchronous reset corners.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] instr_pc_plus2;
  logic        instr_valid;
  logic        decode_ready;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        halted;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus2 (instr_pc_plus2),
    .instr_valid    (instr_valid),
    .decode_ready   (decode_ready),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cyc;
    logic        req;
    logic [15:0] addr;
    logic        iv;
    logic [15:0] ins;
    logic [15:0] pc;
    logic [15:0] p2;
    logic        hlt;
    logic        rdy;
    logic        ren;
    logic [15:0] rpc;
    int          lat;
    logic        hz;
  } vec_t;

  vec_t tbl[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Memory model state
  int          mem_lat = 1;
  logic        hlt_zero = 1'b0;
  logic        pending = 1'b0;
  int          cnt = 0;
  logic [15:0] paddr = 16'h0000;
  logic        req_seen;
  logic [15:0] addr_seen;

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (a == 16'h0006)                 return 16'hA123;
    else if (a == 16'h0040)            return 16'hF040;
    else if (a == 16'hFFFE)            return 16'h1234;
    else if (a == 16'h0000 && hlt_zero) return 16'hF000;
    else                               return 16'h1000 + a;
  endfunction

  function automatic vec_t mk(int c, logic rq, logic [15:0] ad, logic v,
                              logic [15:0] ins, logic [15:0] pc, logic [15:0] p2,
                              logic h, logic rdy, logic ren, logic [15:0] rpc,
                              int lat, logic hz);
    vec_t r;
    r.cyc = c; r.req = rq; r.addr = ad; r.iv = v; r.ins = ins; r.pc = pc;
    r.p2 = p2; r.hlt = h; r.rdy = rdy; r.ren = ren; r.rpc = rpc; r.lat = lat;
    r.hz = hz;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock; memory answers mem_lat cycles after a sampled request.
  task automatic cycle();
    @(negedge clk);
    req_seen  = imem_req && rst_n;
    addr_seen = imem_addr;
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    if (req_seen) begin
      pending = 1'b1;
      cnt     = mem_lat;
      paddr   = addr_seen;
    end
    if (pending) begin
      if (cnt <= 1) begin
        imem_valid = 1'b1;
        imem_rdata = mem_read(paddr);
        pending    = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            cyc req addr    iv ins      pc       p2       h  rdy ren rpc      lat hz
    tbl.push_back(mk( 1,1,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk( 2,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk( 3,0,16'h0000,1,16'h1000,16'h0000,16'h0002,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk( 4,1,16'h0002,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk( 5,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk( 6,0,16'h0000,1,16'h1002,16'h0002,16'h0004,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk( 7,1,16'h0004,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk( 8,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk( 9,0,16'h0000,1,16'h1004,16'h0004,16'h0006,0, 1,0,16'h0000,1,0));
    // backpressure on A123 at 0x0006
    tbl.push_back(mk(10,1,16'h0006,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,1,0));
    tbl.push_back(mk(11,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,1,0));
    for (int c = 12; c <= 16; c++)
      tbl.push_back(mk(c,0,16'h0000,1,16'hA123,16'h0006,16'h0008,0, 0,0,16'h0000,1,0));
    tbl.push_back(mk(17,0,16'h0000,1,16'hA123,16'h0006,16'h0008,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk(18,1,16'h0008,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,0));
    tbl.push_back(mk(19,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,0));
    // redirect in HOLD to 0x0010, then redirect during WAIT to 0x0041
    tbl.push_back(mk(20,0,16'h0000,1,16'h1008,16'h0008,16'h000A,0, 0,1,16'h0010,3,0));
    tbl.push_back(mk(21,1,16'h0010,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,3,0));
    tbl.push_back(mk(22,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 0,1,16'h0041,3,0));
    tbl.push_back(mk(23,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,3,0));
    tbl.push_back(mk(24,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,3,0));
    tbl.push_back(mk(25,1,16'h0040,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,3,0));
    for (int c = 26; c <= 28; c++)
      tbl.push_back(mk(c,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,3,0));
    // HOLD holding an HLT: accept and redirect together -> redirect wins
    tbl.push_back(mk(29,0,16'h0000,1,16'hF040,16'h0040,16'h0042,0, 1,1,16'h0200,1,0));
    tbl.push_back(mk(30,1,16'h0200,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,1,0));
    tbl.push_back(mk(31,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,1,0));
    // redirect to FFFE, wrap to 0000, HLT there
    tbl.push_back(mk(32,0,16'h0000,1,16'h1200,16'h0200,16'h0202,0, 0,1,16'hFFFE,1,0));
    tbl.push_back(mk(33,1,16'hFFFE,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,1,1));
    tbl.push_back(mk(34,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 0,0,16'h0000,1,1));
    tbl.push_back(mk(35,0,16'h0000,1,16'h1234,16'hFFFE,16'h0000,0, 1,0,16'h0000,1,1));
    tbl.push_back(mk(36,1,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,1));
    tbl.push_back(mk(37,0,16'h0000,0,16'h0000,16'h0000,16'h0000,0, 1,0,16'h0000,1,1));
    tbl.push_back(mk(38,0,16'h0000,1,16'hF000,16'h0000,16'h0002,0, 1,0,16'h0000,1,1));
    tbl.push_back(mk(39,0,16'h0000,0,16'h0000,16'h0000,16'h0000,1, 1,0,16'h0000,1,1));

    rst_n        = 1'b0;
    imem_valid   = 1'b0;
    imem_rdata   = 16'h0000;
    decode_ready = 1'b0;
    redirect_en  = 1'b0;
    redirect_pc  = 16'h0000;

    #12;
    chk("rst_instr_valid", instr_valid, 16'h0000);
    chk("rst_halted", halted, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    chk("rst_instr_pc_plus2", instr_pc_plus2, 16'h0000);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 1;

    foreach (tbl[i]) begin
      v = tbl[i];
      while (cyc < v.cyc) cycle();
      chk("req", imem_req, v.req);
      if (v.req) chk("addr", imem_addr, v.addr);
      chk("instr_valid", instr_valid, v.iv);
      if (v.iv) begin
        chk("instr", instr, v.ins);
        chk("instr_pc", instr_pc, v.pc);
        chk("instr_pc_plus2", instr_pc_plus2, v.p2);
      end
      chk("halted", halted, v.hlt);
      decode_ready = v.rdy;
      redirect_en  = v.ren;
      redirect_pc  = v.rpc;
      mem_lat      = v.lat;
      hlt_zero     = v.hz;
    end

    // Halted: redirect pulses and stray memory strobes must not wake fetch.
    for (int i = 0; i < 20; i++) begin
      redirect_en = (i % 2 == 0);
      redirect_pc = 16'h0100;
      cycle();
      imem_valid = (i % 3 == 0);
      imem_rdata = 16'h5555;
      chk("halt_req", imem_req, 16'h0000);
      chk("halt_halted", halted, 16'h0001);
      chk("halt_instr_valid", instr_valid, 16'h0000);
    end
    redirect_en = 1'b0;
    imem_valid  = 1'b0;

    // Asynchronous reset from HALTED clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_halted", halted, 16'h0000);
    chk("arst_instr", instr, 16'h0000);
    chk("arst_instr_pc_plus2", instr_pc_plus2, 16'h0000);
    chk("arst_instr_valid", instr_valid, 16'h0000);

    @(posedge clk);
    #1;
    pending  = 1'b0;
    mem_lat  = 3;
    hlt_zero = 1'b0;
    rst_n    = 1'b1;
    cyc      = 1;
    chk("r1_req", imem_req, 16'h0001);
    chk("r1_addr", imem_addr, 16'h0000);
    cycle();
    chk("r1_wait_req", imem_req, 16'h0000);

    // Reset while WAIT has a request outstanding.
    #2;
    rst_n = 1'b0;
    #1;
    chk("wrst_instr_valid", instr_valid, 16'h0000);
    chk("wrst_halted", halted, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    pending    = 1'b0;
    mem_lat    = 1;
    imem_valid = 1'b1;           // stale response from before reset
    imem_rdata = 16'hF00D;
    rst_n      = 1'b1;
    cyc        = 1;
    chk("r2_req", imem_req, 16'h0001);
    chk("r2_addr", imem_addr, 16'h0000);
    cycle();
    chk("r2_wait_instr_valid", instr_valid, 16'h0000);
    chk("r2_wait_req", imem_req, 16'h0000);
    cycle();
    chk("r2_instr_valid", instr_valid, 16'h0001);
    chk("r2_instr", instr, 16'h1000);
    chk("r2_instr_pc", instr_pc, 16'h0000);
    chk("r2_instr_pc_plus2", instr_pc_plus2, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Consumer side of the program counter: owns the fetch PC, issues reads to a multi-cycle instruction memory and buffers one returned instruction.
- Hands that instruction to decode over a valid/ready handshake.
- Accepts branch redirects from execute.
- Detects HLT (opcode 4'hF) and freezes fetch.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset; bit 0 must be 0.
- HLT_OPC, 4'hF, opcode in instr[15:12] that halts fetch.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- imem_req  output  1  read request; one-cycle pulse.
- imem_addr  output  16  read address; valid while imem_req=1.
- imem_rdata  input  16  instruction data; valid while imem_valid=1.
- imem_valid  input  1  response strobe; one per request, at least 1 cycle after the request.
- instr  output  16  buffered instruction to decode.
- instr_pc  output  16  address of instr.
- instr_pc_plus2  output  16  instr_pc+2, modulo 2^16.
- instr_valid  output  1  instr is presentable to decode.
- decode_ready  input  1  decode accepts instr this cycle.
- redirect_en  input  1  execute-resolved branch target present.
- redirect_pc  input  16  new fetch address; bit 0 forced to 0 internally.
- halted  output  1  HLT delivered; fetch stopped.

Behaviour:
- Reset (asynchronous, any state, mid-transaction included):
  - pc=RESET_PC; state=FETCH.
  - instr, instr_pc and instr_pc_plus2 = 0; instr_valid=0; halted=0.
  - Any outstanding memory response is forgotten; a stale imem_valid after reset release is ignored unless state is WAIT.
- State FETCH:
  - imem_req=1, imem_addr=pc, both combinational from state.
  - Next cycle goes to WAIT; with redirect_en=1 it goes to DRAIN instead.
  - The first request appears in the first cycle after rst_n rises.
- State WAIT:
  - imem_req=0. On imem_valid:
    - instr<=imem_rdata; instr_pc<=pc; instr_pc_plus2<=pc+2.
    - pc<=pc+2, wrapping 16'hFFFE to 16'h0000.
    - Go to HOLD.
  - Redirect in WAIT: pc<=redirect_pc; go to DRAIN (or straight to FETCH if imem_valid is high that same cycle); the returned data is discarded.
- State DRAIN: waits for imem_valid, discards the data, then goes to FETCH. Further redirects update pc only.
- State HOLD:
  - instr_valid=1; instr and instr_pc stay stable until the handshake.
  - decode_ready=1 and not redirect:
    - If instr[15:12]==HLT_OPC, go to HALTED.
    - Otherwise go to FETCH, and the next request starts the following cycle.
  - Redirect has priority over acceptance: pc<=redirect_pc, instr_valid drops next cycle, go to FETCH. The buffered instruction is not counted as accepted.
- State HALTED: halted=1; instr_valid=0; imem_req=0. redirect_en and imem_valid are ignored. Only reset exits.
- Throughput: one instruction per 3 cycles at minimum (FETCH, WAIT with 1-cycle memory, HOLD accept). No overlap or prefetch.
- Memory protocol: at most one outstanding request. imem_valid outside WAIT/DRAIN is a memory protocol violation and is ignored.
- Arithmetic: all PC math is 16-bit unsigned, with no overflow flag.

Test Plan:
- Sequential fetch:
  - Stimulus: release reset, 1-cycle memory returning 16'h1000+addr, decode_ready held 1.
  - Required: imem_addr=0000,0002,0004 on cycles 1,4,7; instr_pc matches; instr_pc_plus2=instr_pc+2.
- Backpressure:
  - Stimulus: decode_ready=0 for 5 cycles in HOLD with instr=16'hA123.
  - Required: instr_valid stays 1, instr and instr_pc stay stable, no imem_req. Next request is issued the cycle after decode_ready=1.
- Redirect during WAIT:
  - Stimulus: 3-cycle memory; redirect_en with redirect_pc=16'h0041 one cycle after the request to 0x0010.
  - Required: the 0x0010 response is dropped (instr_valid never 1 for it); next imem_addr=0x0040.
- Redirect vs accept in HOLD:
  - Stimulus: decode_ready=1 and redirect_en=1 (pc 0x0200) in the same cycle.
  - Required: next imem_addr=0x0200; no halted, even if instr is HLT.
- Wrap and halt:
  - Stimulus: redirect to 16'hFFFE with an ADD instruction there; memory at 0x0000 holds 16'hF000.
  - Required: fetch at FFFE then 0000. instr_pc_plus2=0000 for the FFFE instruction. After HLT is accepted, halted=1 and no further imem_req for 20 cycles despite redirect pulses.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously in WAIT, then release.
  - Required: outputs clear immediately without a clock edge. After release, a stale imem_valid is ignored and the first imem_addr=RESET_PC.
